image_stream_tx: RTL and testbench
==================================

IMAGE_STREAM_TX -- requirements
Module: image_stream_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-002 SHALL have parameter MAX_COLS, default 1280, maximum pixels per row.
REQ-003 SHALL have parameter MAX_ROWS, default 1024, maximum rows per frame.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port resetb  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  start/continue frame generation.
REQ-007 SHALL have port num_cols  input  log2(MAX_COLS+1)  active pixels per row.
REQ-008 SHALL have port num_rows  input  log2(MAX_ROWS+1)  rows per frame.
REQ-009 SHALL have port hblank  input  8  idle cycles after each ROW_END.
REQ-010 SHALL have port vblank  input  16  idle cycles after FRAME_END.
REQ-011 SHALL have port pattern  input  2  0 column ramp, 1 row+column ramp, 2 checkerboard, 3 solid.
REQ-012 SHALL have port dvo  output  1  word valid.
REQ-013 SHALL have port dtypeo  output  DTYPE_WIDTH  word type, dtypes.v codes.
REQ-014 SHALL have port datao  output  DATA_WIDTH  word payload.
REQ-015 SHALL have port busy  output  1  high whenever not in IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, FSTART, RSTART, PIXEL, REND, HBLANK, FEND, VBLANK.
REQ-017 SHALL leave IDLE for FSTART on the first cycle enable=1; frame begins next cycle.
REQ-018 SHALL latch num_cols, num_rows, hblank, vblank, pattern on IDLE->FSTART and VBLANK->FSTART; mid-frame changes are ignored.
REQ-019 SHALL clamp latched num_cols/num_rows: 0 -> 1, above MAX -> MAX.
REQ-020 SHALL emit in FSTART one word dvo=1, dtypeo=DTYPE_FRAME_START.
REQ-021 SHALL emit per row: one RSTART word (DTYPE_ROW_START, datao=row index), then num_cols contiguous PIXEL words (DTYPE_PIXEL), then one REND word (DTYPE_ROW_END).
REQ-022 SHALL hold dvo=0 for exactly latched hblank cycles after each REND except the last row; hblank=0 means RSTART follows REND directly.
REQ-023 SHALL emit after the last row's REND one FEND word (DTYPE_FRAME_END), with no hblank between them.
REQ-024 SHALL hold dvo=0 for latched vblank cycles after FEND, then go to FSTART if enable=1, else IDLE.
REQ-025 SHALL, when enable drops mid-frame, complete the current frame including vblank before IDLE.
REQ-026 SHALL compute pixel data with col, row zero-based and results truncated to DATA_WIDTH: 0 col; 1 row+col; 2 all-ones if (row[3] xor col[3]) else 0; 3 constant 0x80 << (DATA_WIDTH-8).
REQ-027 SHALL register all outputs; word type/data valid in the same cycle as dvo=1.
REQ-028 SHALL drive dtypeo and datao to 0 whenever dvo=0.
REQ-029 SHALL wrap col to 0 at each RSTART and row to 0 at each FSTART.

Reset
REQ-030 SHALL, on resetb low, force state IDLE, dvo=0, dtypeo=0, datao=0, busy=0, counters 0, asynchronously.
REQ-031 SHALL, on reset mid-frame, abandon the frame with no FEND; first word after release with enable=1 is FRAME_START.

Configuration
REQ-032 SHALL, with IMAGE_TX_FRAME_COUNT_EN defined, carry in the FRAME_START word a frame counter (low DATA_WIDTH bits, starting at 0 after reset, incrementing per FEND, wrapping).
REQ-033 SHALL, without IMAGE_TX_FRAME_COUNT_EN, send datao=0 in FRAME_START words and contain no frame counter.

Verification
REQ-034 SHALL cover: cols=4, rows=2, hblank=2, vblank=3, pattern=0, enable pulsed one cycle -> FS, RS(0), 0,1,2,3, RE, 2 idle, RS(1), 0,1,2,3, RE, FE, 3 idle, IDLE; busy low afterwards.
REQ-035 SHALL cover: enable held, cols=2, rows=1, hblank=0, vblank=0 -> back-to-back frames FS,RS,px,px,RE,FE,FS...; with IMAGE_TX_FRAME_COUNT_EN FS data 0,1,2.
REQ-036 SHALL cover: num_cols changed 4->8 mid-frame -> current frame keeps 4 pixels/row, next frame 8.
REQ-037 SHALL cover: cols=0, rows=0 -> one row of one pixel; cols=MAX_COLS+5 -> MAX_COLS pixels.
REQ-038 SHALL cover: pattern=2, cols=16, rows=16 -> pixels toggle 0/all-ones every 8 columns, phase inverted at row 8.
REQ-039 SHALL cover: resetb asserted during PIXEL -> outputs 0 immediately; after release and enable, stream restarts with FS.

Source files
------------

// File: rtl/image_stream_tx_if.sv
// rtl/image_stream_tx_if.sv - word stream bundle (dvo/dtypeo/datao) between image_stream_tx and its sink
interface image_stream_tx_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int DTYPE_WIDTH = 3
);
  logic                   dvo;
  logic [DTYPE_WIDTH-1:0] dtypeo;
  logic [DATA_WIDTH-1:0]  datao;

  modport master (output dvo, output dtypeo, output datao);
  modport slave  (input  dvo, input  dtypeo, input  datao);
endinterface

// File: rtl/image_stream_tx.sv
// rtl/image_stream_tx.sv - test-pattern image frame generator; IMAGE_TX_FRAME_COUNT_EN adds a frame counter in FRAME_START data
module image_stream_tx #(
  parameter int  DATA_WIDTH  = 8,
  parameter int  MAX_COLS    = 1280,
  parameter int  MAX_ROWS    = 1024,
  localparam int CW          = $clog2(MAX_COLS + 1),
  localparam int RW          = $clog2(MAX_ROWS + 1),
  localparam int DTYPE_WIDTH = 3
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             enable,
  input  logic [CW-1:0]    num_cols,
  input  logic [RW-1:0]    num_rows,
  input  logic [7:0]       hblank,
  input  logic [15:0]      vblank,
  input  logic [1:0]       pattern,
  output logic             busy,
  image_stream_tx_if.master tx
);

  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 3'd1;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 3'd2;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START   = 3'd3;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END     = 3'd4;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL       = 3'd5;

  typedef enum logic [2:0] {IDLE, FSTART, RSTART, PIXEL, REND, HBLANK, FEND, VBLANK} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          col_q, col_d, cols_q, cols_d;
  logic [RW-1:0]          row_q, row_d, rows_q, rows_d;
  logic [15:0]            cnt_q, cnt_d, vb_q, vb_d;
  logic [7:0]             hb_q, hb_d;
  logic [1:0]             pat_q, pat_d;
  logic                   dvo_q, dvo_d, busy_q, busy_d;
  logic [DTYPE_WIDTH-1:0] dtype_q, dtype_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d, fs_data;
  logic                   frame_start, frame_done;

  function automatic logic [CW-1:0] clamp_cols(input logic [CW-1:0] v);
    if (v == '0) return CW'(1);
    else if (v > CW'(MAX_COLS)) return CW'(MAX_COLS);
    else return v;
  endfunction

  function automatic logic [RW-1:0] clamp_rows(input logic [RW-1:0] v);
    if (v == '0) return RW'(1);
    else if (v > RW'(MAX_ROWS)) return RW'(MAX_ROWS);
    else return v;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pixel_value(input logic [1:0] pat,
                                                         input logic [RW-1:0] r,
                                                         input logic [CW-1:0] c);
    logic [DATA_WIDTH-1:0] v;
    case (pat)
      2'd0:    v = DATA_WIDTH'(c);
      2'd1:    v = DATA_WIDTH'(r) + DATA_WIDTH'(c);
      2'd2:    v = (r[3] ^ c[3]) ? '1 : '0;
      default: v = DATA_WIDTH'(8'h80) << (DATA_WIDTH - 8);
    endcase
    return v;
  endfunction

`ifdef IMAGE_TX_FRAME_COUNT_EN
  logic [DATA_WIDTH-1:0] fcnt_q, fcnt_d;

  // Counter advances on the FEND word so a directly following FSTART already shows the new count
  assign fcnt_d  = (state_q == FEND) ? fcnt_q + DATA_WIDTH'(1) : fcnt_q;
  assign fs_data = fcnt_d;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) fcnt_q <= '0;
    else         fcnt_q <= fcnt_d;
  end
`else
  assign fs_data = '0;
`endif

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      cols_q  <= '0;
      rows_q  <= '0;
      hb_q    <= '0;
      vb_q    <= '0;
      pat_q   <= '0;
      dvo_q   <= 1'b0;
      dtype_q <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      cols_q  <= cols_d;
      rows_q  <= rows_d;
      hb_q    <= hb_d;
      vb_q    <= vb_d;
      pat_q   <= pat_d;
      dvo_q   <= dvo_d;
      dtype_q <= dtype_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  // Outputs are decoded from the next state so the registered word lines up with the state it belongs to
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    cols_d      = cols_q;
    rows_d      = rows_q;
    hb_d        = hb_q;
    vb_d        = vb_q;
    pat_d       = pat_q;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    dvo_d       = 1'b0;
    dtype_d     = '0;
    data_d      = '0;

    case (state_q)
      IDLE:   frame_start = enable;
      FSTART: state_d = RSTART;
      RSTART: begin
        state_d = PIXEL;
        col_d   = '0;
      end
      PIXEL: begin
        if (col_q == cols_q - CW'(1)) state_d = REND;
        else                          col_d   = col_q + CW'(1);
      end
      REND: begin
        if (row_q == rows_q - RW'(1)) begin
          state_d = FEND;
        end else if (hb_q == 8'd0) begin
          state_d = RSTART;
          row_d   = row_q + RW'(1);
        end else begin
          state_d = HBLANK;
          cnt_d   = 16'(hb_q) - 16'd1;
        end
      end
      HBLANK: begin
        if (cnt_q == 16'd0) begin
          state_d = RSTART;
          row_d   = row_q + RW'(1);
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      FEND: begin
        if (vb_q == 16'd0) begin
          frame_done = 1'b1;
        end else begin
          state_d = VBLANK;
          cnt_d   = vb_q - 16'd1;
        end
      end
      VBLANK: begin
        if (cnt_q == 16'd0) frame_done = 1'b1;
        else                cnt_d = cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase

    if (frame_done) begin
      if (enable) frame_start = 1'b1;
      else        state_d     = IDLE;
    end

    if (frame_start) begin
      state_d = FSTART;
      row_d   = '0;
      col_d   = '0;
      cnt_d   = '0;
      cols_d  = clamp_cols(num_cols);
      rows_d  = clamp_rows(num_rows);
      hb_d    = hblank;
      vb_d    = vblank;
      pat_d   = pattern;
    end

    case (state_d)
      FSTART: begin
        dvo_d   = 1'b1;
        dtype_d = DTYPE_FRAME_START;
        data_d  = fs_data;
      end
      RSTART: begin
        dvo_d   = 1'b1;
        dtype_d = DTYPE_ROW_START;
        data_d  = DATA_WIDTH'(row_d);
      end
      PIXEL: begin
        dvo_d   = 1'b1;
        dtype_d = DTYPE_PIXEL;
        data_d  = pixel_value(pat_d, row_d, col_d);
      end
      REND: begin
        dvo_d   = 1'b1;
        dtype_d = DTYPE_ROW_END;
      end
      FEND: begin
        dvo_d   = 1'b1;
        dtype_d = DTYPE_FRAME_END;
      end
      default: ;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign tx.dvo    = dvo_q;
  assign tx.dtypeo = dtype_q;
  assign tx.datao  = data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_image_stream_tx.sv
// tb/tb_image_stream_tx.sv - scoreboard bench for image_stream_tx with a frame-level reference model
module tb_image_stream_tx;
  localparam int DW   = 8;
  localparam int MAXC = 40;
  localparam int MAXR = 20;
  localparam int CWT  = $clog2(MAXC + 1);
  localparam int RWT  = $clog2(MAXR + 1);
  localparam int T_FS = 1, T_FE = 2, T_RS = 3, T_RE = 4, T_PX = 5;

  logic           clk = 1'b0;
  logic           resetb = 1'b0;
  logic           enable = 1'b0;
  logic [CWT-1:0] num_cols = '0;
  logic [RWT-1:0] num_rows = '0;
  logic [7:0]     hblank = '0;
  logic [15:0]    vblank = '0;
  logic [1:0]     pattern = '0;
  logic           busy;

  image_stream_tx_if #(.DATA_WIDTH(DW), .DTYPE_WIDTH(3)) tx_if ();

  image_stream_tx #(.DATA_WIDTH(DW), .MAX_COLS(MAXC), .MAX_ROWS(MAXR)) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .num_cols(num_cols), .num_rows(num_rows),
    .hblank(hblank), .vblank(vblank), .pattern(pattern), .busy(busy), .tx(tx_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int dtype;
    int data;
    int gap;
    int at;
    int bchk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   idle_run = 0;
  int   bc_target = -1;
  int   frames_done = 0;

  function automatic int pix_model(int p, int r, int c);
    int m = (1 << DW) - 1;
    case (p)
      0:       return c & m;
      1:       return (r + c) & m;
      2:       return (((r / 8) % 2) != ((c / 8) % 2)) ? m : 0;
      default: return (128 << (DW - 8)) & m;
    endcase
  endfunction

  function automatic void push_word(int t, int d, int g, int a, int b);
    exp_t e;
    e.dtype = t; e.data = d; e.gap = g; e.at = a; e.bchk = b;
    exp_q.push_back(e);
  endfunction

  function automatic void push_frame(int c_in, int r_in, int hb, int vb, int pat,
                                     int fs_gap, int fs_at, bit last);
    int c = (c_in == 0) ? 1 : ((c_in > MAXC) ? MAXC : c_in);
    int r = (r_in == 0) ? 1 : ((r_in > MAXR) ? MAXR : r_in);
    int fsd = 0;
`ifdef IMAGE_TX_FRAME_COUNT_EN
    fsd = frames_done % (1 << DW);
`endif
    push_word(T_FS, fsd, fs_gap, fs_at, -1);
    for (int ri = 0; ri < r; ri++) begin
      push_word(T_RS, ri % (1 << DW), (ri == 0) ? 0 : hb, -1, -1);
      for (int ci = 0; ci < c; ci++) push_word(T_PX, pix_model(pat, ri, ci), 0, -1, -1);
      push_word(T_RE, 0, 0, -1, -1);
    end
    push_word(T_FE, 0, 0, -1, last ? vb : -1);
    frames_done++;
  endfunction

  // Monitor: every falling edge either consumes a word from the scoreboard or checks an idle cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!resetb) begin
        idle_run  = 0;
        bc_target = -1;
        checks++;
        if (tx_if.dvo !== 1'b0 || tx_if.dtypeo !== '0 || tx_if.datao !== '0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL reset_outputs dvo=%0b dtype=%0d data=%0d busy=%0b required all 0",
                   tx_if.dvo, tx_if.dtypeo, tx_if.datao, busy);
        end
      end else begin
        if (tx_if.dvo === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_word cyc=%0d dtype=%0d data=%0d required none", cyc, tx_if.dtypeo, tx_if.datao);
          end else begin
            e = exp_q.pop_front();
            if (int'(tx_if.dtypeo) != e.dtype) begin
              failures++;
              $display("FAIL word_type cyc=%0d got=%0d required=%0d", cyc, tx_if.dtypeo, e.dtype);
            end
            checks++;
            if (int'(tx_if.datao) != e.data) begin
              failures++;
              $display("FAIL word_data cyc=%0d type=%0d got=%0d required=%0d", cyc, e.dtype, tx_if.datao, e.data);
            end
            if (e.gap >= 0) begin
              checks++;
              if (idle_run != e.gap) begin
                failures++;
                $display("FAIL idle_gap cyc=%0d type=%0d got=%0d required=%0d", cyc, e.dtype, idle_run, e.gap);
              end
            end
            if (e.at >= 0) begin
              checks++;
              if (cyc != e.at) begin
                failures++;
                $display("FAIL start_latency got_cyc=%0d required_cyc=%0d", cyc, e.at);
              end
            end
            if (e.bchk >= 0) bc_target = cyc + e.bchk;
          end
          idle_run = 0;
        end else begin
          idle_run++;
          checks++;
          if (tx_if.dvo !== 1'b0 || tx_if.dtypeo !== '0 || tx_if.datao !== '0) begin
            failures++;
            $display("FAIL idle_outputs cyc=%0d dvo=%0b dtype=%0d data=%0d required 0", cyc, tx_if.dvo, tx_if.dtypeo, tx_if.datao);
          end
        end
        if (bc_target >= 0) begin
          if (cyc == bc_target) begin
            checks++;
            if (busy !== 1'b1) begin
              failures++;
              $display("FAIL busy_in_vblank cyc=%0d got=%0b required=1", cyc, busy);
            end
          end else if (cyc == bc_target + 1) begin
            checks++;
            if (busy !== 1'b0) begin
              failures++;
              $display("FAIL busy_after_frame cyc=%0d got=%0b required=0", cyc, busy);
            end
            bc_target = -1;
          end
        end
      end
    end
  end

  task automatic set_cfg(int c, int r, int hb, int vb, int pat);
    num_cols = CWT'(c);
    num_rows = RWT'(r);
    hblank   = 8'(hb);
    vblank   = 16'(vb);
    pattern  = 2'(pat);
  endtask

  task automatic wait_drain(int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bc_target >= 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || bc_target >= 0) begin
      $display("FAIL drain_timeout words_left=%0d required 0", exp_q.size());
      $fatal(1, "scoreboard did not drain");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_size_le(int lim, int budget);
    int n = 0;
    while (exp_q.size() > lim && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > lim) begin
      $display("FAIL progress_timeout words_left=%0d required<=%0d", exp_q.size(), lim);
      $fatal(1, "stream stalled");
    end
  endtask

  task automatic run_frame(int c, int r, int hb, int vb, int pat);
    set_cfg(c, r, hb, vb, pat);
    @(negedge clk);
    push_frame(c, r, hb, vb, pat, -1, cyc + 1, 1'b1);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_drain(3000);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int na, nb, n;
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame with enable pulsed for one cycle
    run_frame(4, 2, 2, 3, 0);

    // Back-to-back frames with enable held
    set_cfg(2, 1, 0, 0, 0);
    @(negedge clk);
    push_frame(2, 1, 0, 0, 0, -1, cyc + 1, 1'b0);
    push_frame(2, 1, 0, 0, 0, 0, -1, 1'b0);
    push_frame(2, 1, 0, 0, 0, 0, -1, 1'b1);
    enable = 1'b1;
    wait_size_le(5, 200);
    enable = 1'b0;
    wait_drain(200);

    // Mid-frame num_cols change only affects the following frame
    set_cfg(4, 2, 1, 2, 1);
    @(negedge clk);
    push_frame(4, 2, 1, 2, 1, -1, cyc + 1, 1'b0);
    na = exp_q.size();
    push_frame(8, 2, 1, 2, 1, 2, -1, 1'b1);
    nb = exp_q.size() - na;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    num_cols = CWT'(8);
    wait_size_le(nb - 1, 300);
    enable = 1'b0;
    wait_drain(300);

    // Clamping of zero and oversize dimensions
    run_frame(0, 0, 1, 1, 1);
    run_frame(MAXC + 5, 2, 0, 0, 3);
    run_frame(3, MAXR + 5, 0, 0, 1);

    // Checkerboard
    run_frame(16, 16, 0, 1, 2);

    // Randomized frames
    for (int i = 0; i < 10; i++)
      run_frame($urandom_range(0, MAXC + 3), $urandom_range(0, 4), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));

    // Asynchronous reset during PIXEL, then restart
    set_cfg(20, 2, 1, 1, 0);
    @(negedge clk);
    push_frame(20, 2, 1, 1, 0, -1, cyc + 1, 1'b1);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    n = 0;
    while (!(tx_if.dvo === 1'b1 && int'(tx_if.dtypeo) == T_PX) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(tx_if.dvo === 1'b1 && int'(tx_if.dtypeo) == T_PX)) begin
      $display("FAIL pixel_wait_timeout dtype=%0d required=%0d", tx_if.dtypeo, T_PX);
      $fatal(1, "no pixel seen");
    end
    @(posedge clk);
    #2;
    resetb = 1'b0;
    exp_q.delete();
    frames_done = 0;
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    repeat (3) @(negedge clk);
    run_frame(3, 2, 0, 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
